// File: rtl/tpu_sequencer.sv
// Instruction-driven front end for the 2x2 systolic array: fetches four words, then loads weights or streams skewed activations.
// Optional TPU_SEQ_ILLEGAL_TRAP_EN adds a sticky illegal_op output and a halting TRAP state.
module tpu_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              load_weight,
    output logic [DATA_W-1:0] weight1,
    output logic [DATA_W-1:0] weight2,
    output logic [DATA_W-1:0] weight3,
    output logic [DATA_W-1:0] weight4,
    output logic              valid,
    output logic [DATA_W-1:0] a_in1,
    output logic [DATA_W-1:0] a_in2,
    output logic              busy,
`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
    output logic              illegal_op,
`endif
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOADW,
        S_STREAM,
        S_DRAIN,
        S_DONE
`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_is_compute;
    logic [ADDR_W-1:0] r_base;
    logic [DATA_W-1:0] r_word [0:3];
    logic              r_ready;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_addr;
    logic              r_lw;
    logic [DATA_W-1:0] r_w1, r_w2, r_w3, r_w4;
    logic              r_valid;
    logic [DATA_W-1:0] r_a1, r_a2;
    logic              r_done;
    logic              w_unused;

    // Operand bits above the address field carry no meaning for any opcode.
    assign w_unused = ^instr[12:ADDR_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_is_compute <= 1'b0;
            r_base       <= '0;
            for (int i = 0; i < 4; i++) r_word[i] <= '0;
            r_ready      <= 1'b1;
            r_rd_en      <= 1'b0;
            r_addr       <= '0;
            r_lw         <= 1'b0;
            r_w1         <= '0;
            r_w2         <= '0;
            r_w3         <= '0;
            r_w4         <= '0;
            r_valid      <= 1'b0;
            r_a1         <= '0;
            r_a2         <= '0;
            r_done       <= 1'b0;
`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
            illegal_op   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        case (instr[15:13])
                            3'b000: r_base <= instr[ADDR_W-1:0];
                            3'b001, 3'b010: begin
                                r_state      <= S_FETCH;
                                r_cnt        <= '0;
                                r_is_compute <= (instr[15:13] == 3'b010);
                                r_ready      <= 1'b0;
                                r_rd_en      <= 1'b1;
                                r_addr       <= r_base;
                            end
                            3'b011: ;
                            default: begin
`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
                                r_state    <= S_TRAP;
                                r_ready    <= 1'b0;
                                illegal_op <= 1'b1;
`endif
                            end
                        endcase
                    end
                end
                S_FETCH: begin
                    // Read data lags the strobe by one cycle, so word[cnt-1] lands at the end of cnt.
                    if (r_cnt != 4'd0) r_word[r_cnt[1:0] - 2'd1] <= mem_rdata;
                    if (r_cnt < 4'd3) begin
                        r_rd_en <= 1'b1;
                        r_addr  <= r_base + ADDR_W'(r_cnt + 4'd1);
                    end else begin
                        r_rd_en <= 1'b0;
                        r_addr  <= '0;
                    end
                    if (r_cnt == 4'd4) begin
                        r_cnt <= '0;
                        if (r_is_compute) begin
                            r_state <= S_STREAM;
                            r_valid <= 1'b1;
                            r_a1    <= r_word[0];
                            r_a2    <= '0;
                        end else begin
                            r_state <= S_LOADW;
                            r_lw    <= 1'b1;
                            r_w1    <= r_word[0];
                            r_w2    <= r_word[1];
                            r_w3    <= r_word[2];
                            r_w4    <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_LOADW: begin
                    r_lw    <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_STREAM: begin
                    case (r_cnt)
                        4'd0: begin
                            r_a1  <= r_word[1];
                            r_a2  <= r_word[2];
                            r_cnt <= 4'd1;
                        end
                        4'd1: begin
                            r_a1  <= '0;
                            r_a2  <= r_word[3];
                            r_cnt <= 4'd2;
                        end
                        default: begin
                            r_a1    <= '0;
                            r_a2    <= '0;
                            r_cnt   <= '0;
                            r_state <= S_DRAIN;
                        end
                    endcase
                end
                S_DRAIN: begin
                    if (r_cnt == 4'(DRAIN_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
                S_TRAP: ;
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign busy        = ~r_ready;
    assign mem_rd_en   = r_rd_en;
    assign mem_addr    = r_addr;
    assign load_weight = r_lw;
    assign weight1     = r_w1;
    assign weight2     = r_w2;
    assign weight3     = r_w3;
    assign weight4     = r_w4;
    assign valid       = r_valid;
    assign a_in1       = r_a1;
    assign a_in2       = r_a2;
    assign done        = r_done;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Self-checking bench for tpu_sequencer: a per-cycle expected-output timeline model plus directed literal checks.
module tb_tpu_sequencer;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DRAIN  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready, mem_rd_en, load_weight, valid, busy, done;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] weight1, weight2, weight3, weight4, a_in1, a_in2;
`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  tpu_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .load_weight(load_weight),
    .weight1(weight1), .weight2(weight2), .weight3(weight3), .weight4(weight4),
    .valid(valid), .a_in1(a_in1), .a_in2(a_in2), .busy(busy),
`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .done(done)
  );

  // synchronous memory, data one cycle after the strobe
  logic [15:0] mem [0:255];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        rdy, bsy, rd;
    logic [7:0]  addr;
    logic        lw;
    logic [15:0] w1, w2, w3, w4;
    logic        vld;
    logic [15:0] a1, a2;
    logic        dn, ill;
  } vec_t;

  vec_t        m_q[$];
  vec_t        m_cur = '0;
  logic [7:0]  m_base = '0;
  logic [15:0] m_w [0:3] = '{default: '0};
  logic        m_trap = 1'b0;

  function automatic vec_t idle_vec();
    vec_t v = '0;
    v.rdy = !m_trap;
    v.bsy = m_trap;
    v.ill = m_trap;
    v.w1 = m_w[0]; v.w2 = m_w[1]; v.w3 = m_w[2]; v.w4 = m_w[3];
    return v;
  endfunction

  // Expand an accepted instruction into the outputs of every following cycle.
  task automatic model_accept(input logic [15:0] ins);
    vec_t v, f;
    logic [15:0] wd [0:3];
    logic [7:0]  a;
    v = '0;
    v.bsy = 1'b1;
    v.w1 = m_w[0]; v.w2 = m_w[1]; v.w3 = m_w[2]; v.w4 = m_w[3];
    case (ins[15:13])
      3'b000: m_base = ins[7:0];
      3'b001, 3'b010: begin
        for (int i = 0; i < 5; i++) begin
          f = v;
          if (i < 4) begin
            a = m_base + 8'(i);
            f.rd = 1'b1;
            f.addr = a;
            wd[i] = mem[a];
          end
          m_q.push_back(f);
        end
        if (ins[15:13] == 3'b001) begin
          for (int i = 0; i < 4; i++) m_w[i] = wd[i];
          v.w1 = wd[0]; v.w2 = wd[1]; v.w3 = wd[2]; v.w4 = wd[3];
          f = v; f.lw = 1'b1; m_q.push_back(f);
        end else begin
          f = v; f.vld = 1'b1; f.a1 = wd[0]; f.a2 = '0;    m_q.push_back(f);
          f = v; f.vld = 1'b1; f.a1 = wd[1]; f.a2 = wd[2]; m_q.push_back(f);
          f = v; f.vld = 1'b1; f.a1 = '0;    f.a2 = wd[3]; m_q.push_back(f);
          for (int i = 0; i < DRAIN; i++) begin
            f = v; f.vld = 1'b1; m_q.push_back(f);
          end
        end
        f = v; f.dn = 1'b1; m_q.push_back(f);
      end
      3'b011: ;
      default: begin
`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
        m_trap = 1'b1;
`endif
      end
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_base = '0;
      for (int i = 0; i < 4; i++) m_w[i] = '0;
      m_trap = 1'b0;
      m_cur = idle_vec();
    end else begin
      if (m_cur.rdy && instr_valid) model_accept(instr);
      if (m_q.size() > 0) m_cur = m_q.pop_front();
      else m_cur = idle_vec();
    end
  end

  // ---------------- compare process and event log ----------------
  function automatic vec_t dut_vec();
    vec_t v;
    v.rdy = instr_ready; v.bsy = busy; v.rd = mem_rd_en; v.addr = mem_addr;
    v.lw = load_weight; v.w1 = weight1; v.w2 = weight2; v.w3 = weight3; v.w4 = weight4;
    v.vld = valid; v.a1 = a_in1; v.a2 = a_in2; v.dn = done;
`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
    v.ill = illegal_op;
`else
    v.ill = 1'b0;
`endif
    return v;
  endfunction

  bit           cmp_en = 1'b0;
  int           cyc = 0;
  int           acc_cyc = 0, lw_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic [7:0]   addr_log[$];
  logic [31:0]  strm_log[$];

  always @(negedge clk) begin
    vec_t d;
    cyc++;
    if (cmp_en) begin
      d = dut_vec();
      n_checks++;
      if (d !== m_cur) begin
        n_errors++;
        $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h", cyc, d, m_cur);
      end
    end
    if (instr_valid && instr_ready) acc_cyc = cyc;
    if (load_weight) lw_cyc = cyc;
    if (done) begin done_cyc = cyc; done_cnt++; end
    if (mem_rd_en) addr_log.push_back(mem_addr);
    if (valid) strm_log.push_back({a_in1, a_in2});
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [12:0] opnd);
    bit ok = 1'b0;
    instr = {op, opnd};
    instr_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (instr_ready) ok = 1'b1;
    end
    check("accept_within_budget", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int s = done_cnt;
    for (int i = 0; i < budget && done_cnt == s; i++) @(posedge clk);
    check("done_within_budget", 64'(done_cnt > s), 64'd1);
    #1;
  endtask

  // ---------------- main sequence ----------------
  logic [7:0]  exp_q[$];
  logic [31:0] exp_s[$];
  int a0, a1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // reset held for two cycles
    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ready", 64'(instr_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_weight1", 64'(weight1), 64'd0);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_ready", 64'(instr_ready), 64'd1);

    // load weights
    mem[0] = 16'd3; mem[1] = 16'd5; mem[2] = 16'd4; mem[3] = 16'd6;
    send(3'b000, 13'd0);
    addr_log.delete();
    send(3'b001, 13'd0);
    a0 = acc_cyc;
    wait_done(50);
    check("lw_latency", 64'(lw_cyc - a0), 64'd6);
    check("lw_done_latency", 64'(done_cyc - a0), 64'd7);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3};
    check("lw_addr_count", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check("lw_addr", 64'(addr_log[i]), 64'(exp_q[i]));
    check("weight1", 64'(weight1), 64'd3);
    check("weight2", 64'(weight2), 64'd5);
    check("weight3", 64'(weight3), 64'd4);
    check("weight4", 64'(weight4), 64'd6);

    // compute
    mem[4] = 16'd11; mem[5] = 16'd12; mem[6] = 16'd21; mem[7] = 16'd22;
    mem[8] = 16'd7;  mem[9] = 16'd8;  mem[10] = 16'd9; mem[11] = 16'd10;
    send(3'b000, 13'd4);
    strm_log.delete();
    send(3'b010, 13'd0);
    a0 = acc_cyc;
    // busy stall: LOAD_ADDR presented during FETCH
    send(3'b000, 13'd8);
    a1 = acc_cyc;
    check("compute_done_latency", 64'(done_cyc - a0), 64'(9 + DRAIN));
    check("stall_accept_cycle", 64'(a1 - a0), 64'(10 + DRAIN));
    exp_s = '{32'h000b_0000, 32'h000c_0015, 32'h0000_0016, 32'h0, 32'h0, 32'h0, 32'h0};
    check("valid_cycles", 64'(strm_log.size()), 64'd7);
    for (int i = 0; i < 7 && i < strm_log.size(); i++) check("stream_pair", 64'(strm_log[i]), 64'(exp_s[i]));
    check("weight1_held", 64'(weight1), 64'd3);
    check("weight4_held", 64'(weight4), 64'd6);
    addr_log.delete();
    send(3'b010, 13'd0);
    wait_done(50);
    exp_q = '{8'd8, 8'd9, 8'd10, 8'd11};
    check("stall_addr_count", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check("stall_addr", 64'(addr_log[i]), 64'(exp_q[i]));

    // wrap
    mem[254] = 16'h0a0a; mem[255] = 16'h0b0b; mem[0] = 16'h0c0c; mem[1] = 16'h0d0d;
    send(3'b000, 13'd254);
    addr_log.delete();
    send(3'b001, 13'd0);
    wait_done(50);
    exp_q = '{8'd254, 8'd255, 8'd0, 8'd1};
    check("wrap_addr_count", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check("wrap_addr", 64'(addr_log[i]), 64'(exp_q[i]));
    check("wrap_weight3", 64'(weight3), 64'h0c0c);

    // abort during FETCH cnt=2
    send(3'b001, 13'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_ready", 64'(instr_ready), 64'd1);
    check("abort_rd_en", 64'(mem_rd_en), 64'd0);
    check("abort_weights", 64'({weight1, weight2, weight3, weight4}), 64'd0);
    a0 = done_cnt;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(a0));

    // illegal opcode 101
`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
    send(3'b101, 13'd0);
    repeat (3) @(negedge clk);
    check("trap_illegal_op", 64'(illegal_op), 64'd1);
    check("trap_ready", 64'(instr_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("trap_cleared", 64'(illegal_op), 64'd0);
`else
    send(3'b101, 13'd0);
    a0 = acc_cyc;
    send(3'b011, 13'd0);
    check("illegal_next_accept", 64'(acc_cyc - a0), 64'd1);
`endif

    // randomized phase
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 80; n++) begin
      logic [2:0] op;
`ifdef TPU_SEQ_ILLEGAL_TRAP_EN
      op = 3'($urandom_range(0, 3));
`else
      op = 3'($urandom_range(0, 7));
`endif
      send(op, 13'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (30) @(posedge clk);
    #1;
    check("final_idle", 64'(instr_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
